// File: rtl/aes_ctr_pkg.sv
// Shared widths, counter-block layout and keystream slice helper
// for the AES-CTR video keystream scheduler.
package aes_ctr_pkg;

    localparam int PIX_W   = 24;
    localparam int BLK_W   = 128;
    localparam int NONCE_W = 64;
    localparam int FRAME_W = 32;
    localparam int IDX_W   = 32;

    localparam int CTR_IDX_LSB   = 0;
    localparam int CTR_FRAME_LSB = CTR_IDX_LSB + IDX_W;
    localparam int CTR_NONCE_LSB = CTR_FRAME_LSB + FRAME_W;

    function automatic logic [BLK_W-1:0] ctr_blk(
        input logic [NONCE_W-1:0] n,
        input logic [FRAME_W-1:0] f,
        input logic [IDX_W-1:0]   i
    );
        logic [BLK_W-1:0] b;
        b = '0;
        b[CTR_NONCE_LSB +: NONCE_W] = n;
        b[CTR_FRAME_LSB +: FRAME_W] = f;
        b[CTR_IDX_LSB   +: IDX_W]   = i;
        return b;
    endfunction

    // Slice k is taken MSB-first; the low leftover bits are never used.
    function automatic logic [PIX_W-1:0] ks_slice(
        input logic [BLK_W-1:0] blk,
        input logic [7:0]       k
    );
        logic [BLK_W-1:0] s;
        s = blk << (k * 8'(PIX_W));
        return s[BLK_W-1 -: PIX_W];
    endfunction

endpackage

// File: rtl/aes_ks_buf.sv
// Two-entry keystream block buffer with simultaneous write/pop
// and a synchronous flush.
module aes_ks_buf
    import aes_ctr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_i,
    input  logic [BLK_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [BLK_W-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [BLK_W-1:0] mem_q [2];
    logic             wp_q, rp_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_wr, do_pop;

    always_comb begin
        do_wr  = wr_i & (cnt_q != 2'd2);
        do_pop = pop_i & (cnt_q != 2'd0);
        cnt_d  = cnt_q;
        unique case ({do_wr, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= ~wp_q;
            end
            if (do_pop) rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/aes_ctr_ks_sched.sv
// Prefetches AES-CTR keystream blocks and hands them out as
// 24-bit pixel slices aligned to the video raster.
module aes_ctr_ks_sched
    import aes_ctr_pkg::*;
#(
    parameter int H_RESOLUTION = 1920,
    parameter int V_RESOLUTION = 1080,
    parameter int PIX_PER_BLK  = 5
) (
    input  logic               axis_aclk,
    input  logic               axis_aresetn,
    input  logic [NONCE_W-1:0] cfg_nonce,
    input  logic               cfg_restart,
    output logic               aes_req,
    output logic [BLK_W-1:0]   aes_ctr_blk,
    input  logic               aes_ack,
    input  logic               aes_ks_valid,
    input  logic [BLK_W-1:0]   aes_ks,
    output logic               ks_valid,
    output logic [PIX_W-1:0]   ks_pixel,
    output logic               ks_tuser,
    output logic               ks_tlast,
    input  logic               pix_fire,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               err_underrun
);

    localparam int BLKS =
        (H_RESOLUTION * V_RESOLUTION + PIX_PER_BLK - 1) / PIX_PER_BLK;

    logic [15:0]        x_q, x_d, y_q, y_d;
    logic [2:0]         sl_q, sl_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [FRAME_W-1:0] rfrm_q, rfrm_d;
    logic               req_q, req_d;
    logic               infl_q, infl_d;
    logic               drop_q, drop_d;
    logic               err_q, err_d;

    logic [BLK_W-1:0]   head;
    logic [1:0]         cnt;
    logic               fire, pop, wr;
    logic               line_end, frame_end, last_sl;

    aes_ks_buf u_buf (
        .clk_i   (axis_aclk),
        .rst_ni  (axis_aresetn),
        .flush_i (cfg_restart),
        .wr_i    (wr),
        .wdata_i (aes_ks),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (cnt)
    );

    assign ks_valid  = (cnt != 2'd0);
    assign line_end  = (x_q == 16'(H_RESOLUTION - 1));
    assign frame_end = line_end & (y_q == 16'(V_RESOLUTION - 1));
    assign last_sl   = (sl_q == 3'(PIX_PER_BLK - 1));
    assign fire      = pix_fire & ks_valid & ~cfg_restart;
    assign pop       = fire & (last_sl | frame_end);
    assign wr        = aes_ks_valid & infl_q & ~drop_q & ~cfg_restart;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        sl_d   = sl_q;
        fcnt_d = fcnt_q;
        ridx_d = ridx_q;
        rfrm_d = rfrm_q;
        req_d  = req_q;
        infl_d = infl_q;
        drop_d = drop_q;
        err_d  = err_q;
        if (cfg_restart) begin
            x_d    = '0;
            y_d    = '0;
            sl_d   = '0;
            fcnt_d = '0;
            ridx_d = '0;
            rfrm_d = '0;
            req_d  = 1'b0;
            // A block still owed by the core must be swallowed on arrival.
            infl_d = (infl_q & ~aes_ks_valid) | (req_q & aes_ack);
            drop_d = infl_d;
        end else begin
            if (pix_fire & ~ks_valid) err_d = 1'b1;
            if (fire) begin
                sl_d = pop ? 3'd0 : sl_q + 3'd1;
                if (line_end) begin
                    x_d = '0;
                    if (frame_end) begin
                        y_d    = '0;
                        fcnt_d = fcnt_q + 32'd1;
                    end else begin
                        y_d = y_q + 16'd1;
                    end
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
            if (req_q & aes_ack) begin
                req_d  = 1'b0;
                infl_d = 1'b1;
                if (ridx_q == 32'(BLKS - 1)) begin
                    ridx_d = '0;
                    rfrm_d = rfrm_q + 32'd1;
                end else begin
                    ridx_d = ridx_q + 32'd1;
                end
            end else if (infl_q & aes_ks_valid) begin
                infl_d = 1'b0;
                drop_d = 1'b0;
            end else if (!req_q & !infl_q & (cnt != 2'd2)) begin
                req_d = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            x_q    <= '0;
            y_q    <= '0;
            sl_q   <= '0;
            fcnt_q <= '0;
            ridx_q <= '0;
            rfrm_q <= '0;
            req_q  <= 1'b0;
            infl_q <= 1'b0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            sl_q   <= sl_d;
            fcnt_q <= fcnt_d;
            ridx_q <= ridx_d;
            rfrm_q <= rfrm_d;
            req_q  <= req_d;
            infl_q <= infl_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    assign aes_req      = req_q;
    assign aes_ctr_blk  = req_q ? ctr_blk(cfg_nonce, rfrm_q, ridx_q) : '0;
    assign ks_pixel     = ks_valid ? ks_slice(head, 8'(sl_q)) : '0;
    assign ks_tuser     = ks_valid & (x_q == 16'd0) & (y_q == 16'd0);
    assign ks_tlast     = ks_valid & line_end;
    assign frame_cnt    = fcnt_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_aes_ctr_ks_sched.sv
// Directed bench for the keystream scheduler on a 4x2 raster
// (two keystream blocks per frame).
module tb_aes_ctr_ks_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  nonce;
    logic         restart;
    logic         aes_req;
    logic [127:0] ctr;
    logic         ack;
    logic         ksv;
    logic [127:0] ks;
    logic         kv;
    logic [23:0]  pix;
    logic         tuser, tlast;
    logic         fire;
    logic [31:0]  fcnt;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] KS0 = 128'h001122_334455_667788_99AABB_CCDDEE_FF;
    localparam logic [127:0] KS1 = 128'h111111_222222_333333_444444_555555_66;
    localparam logic [127:0] KS2 = 128'hAAAAAA_BBBBBB_CCCCCC_DDDDDD_EEEEEE_00;
    localparam logic [127:0] KS3 = 128'h123456_789ABC_DEF012_345678_9ABCDE_F0;

    logic [23:0] exp_pix [8] = '{24'h001122, 24'h334455, 24'h667788,
                                 24'h99AABB, 24'hCCDDEE, 24'h111111,
                                 24'h222222, 24'h333333};

    aes_ctr_ks_sched #(
        .H_RESOLUTION (4),
        .V_RESOLUTION (2),
        .PIX_PER_BLK  (5)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .cfg_nonce    (nonce),
        .cfg_restart  (restart),
        .aes_req      (aes_req),
        .aes_ctr_blk  (ctr),
        .aes_ack      (ack),
        .aes_ks_valid (ksv),
        .aes_ks       (ks),
        .ks_valid     (kv),
        .ks_pixel     (pix),
        .ks_tuser     (tuser),
        .ks_tlast     (tlast),
        .pix_fire     (fire),
        .frame_cnt    (fcnt),
        .err_underrun (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] cb(input logic [31:0] f,
                                        input logic [31:0] i);
        return {64'hA5, f, i};
    endfunction

    logic [127:0] held;

    initial begin
        rst_n = 1'b0; nonce = 64'hA5; restart = 1'b0;
        ack = 1'b0; ksv = 1'b0; ks = '0; fire = 1'b0;
        step();
        step();
        chk("rst_req", aes_req, 0);
        chk("rst_ctr", ctr, 0);
        chk("rst_kv", kv, 0);
        chk("rst_pix", pix, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_err", err, 0);

        rst_n = 1'b1;
        step();
        chk("req0", aes_req, 1);
        chk("ctr0", ctr, cb(0, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("req0_hold", aes_req, 1);
            chk("ctr0_hold", ctr, cb(0, 0));
        end
        ack = 1'b1; step(); ack = 1'b0;
        chk("req0_drop", aes_req, 0);
        ksv = 1'b1; ks = KS0; step(); ksv = 1'b0;
        chk("ks0_valid", kv, 1);
        chk("ks0_pix", pix, 24'h001122);
        step();
        chk("req1", aes_req, 1);
        chk("ctr1", ctr, cb(0, 1));
        ack = 1'b1; step(); ack = 1'b0;
        ksv = 1'b1; ks = KS1; step(); ksv = 1'b0;
        chk("full_noreq", aes_req, 0);

        for (int i = 0; i < 8; i++) begin
            chk("f0_kv", kv, 1);
            chk("f0_pix", pix, exp_pix[i]);
            chk("f0_tuser", tuser, (i == 0));
            chk("f0_tlast", tlast, (i % 4 == 3));
            if (i == 5) chk("req2_wait", aes_req, 0);
            if (i == 6) chk("ctr2", ctr, cb(1, 0));
            if (i == 7) chk("f0_fcnt0", fcnt, 0);
            fire = 1'b1; step(); fire = 1'b0;
        end
        chk("f0_fcnt1", fcnt, 1);
        chk("f0_empty", kv, 0);

        ack = 1'b1; step(); ack = 1'b0;
        fire = 1'b1; step(); fire = 1'b0;
        chk("under_err", err, 1);
        chk("under_kv", kv, 0);
        ksv = 1'b1; ks = KS2; step(); ksv = 1'b0;
        chk("ks2_pix", pix, 24'hAAAAAA);
        chk("ks2_tuser", tuser, 1);
        chk("under_sticky", err, 1);
        chk("under_fcnt", fcnt, 1);
        step();
        chk("ctr3", ctr, cb(1, 1));
        ack = 1'b1; step(); ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fire = 1'b1; step(); fire = 1'b0;
        end
        chk("sl4_pix", pix, 24'hEEEEEE);
        fire = 1'b1; ksv = 1'b1; ks = KS3; step();
        fire = 1'b0; ksv = 1'b0;
        chk("wrpop_kv", kv, 1);
        chk("wrpop_pix", pix, 24'h123456);
        chk("wrpop_tuser", tuser, 0);
        chk("wrpop_req0", aes_req, 0);
        step();
        chk("wrpop_req1", aes_req, 1);
        chk("ctr4", ctr, cb(2, 0));
        ack = 1'b1; step(); ack = 1'b0;
        chk("one_req_a", aes_req, 0);
        step();
        chk("one_req_b", aes_req, 0);

        restart = 1'b1; step(); restart = 1'b0;
        chk("rs_kv", kv, 0);
        chk("rs_fcnt", fcnt, 0);
        chk("rs_req", aes_req, 0);
        chk("rs_err", err, 1);
        ksv = 1'b1; ks = KS1; step(); ksv = 1'b0;
        chk("late_kv", kv, 0);
        chk("late_req", aes_req, 0);
        step();
        chk("rs_req1", aes_req, 1);
        chk("rs_ctr", ctr, cb(0, 0));
        held = ctr;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_req", aes_req, 1);
            chk("stall_ctr", ctr, held);
        end
        ack = 1'b1; step(); ack = 1'b0;
        chk("stall_ack", aes_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
